nios_ii_system_timer_master: RTL

Avalon-MM master that drives the system's 16-bit-data interval timer slave from hardware, with no CPU involvement. On a start command it programs the period, starts the timer and polls the status register. Each timeout is acknowledged by clearing status and is reported to fabric logic as a one-cycle tick pulse plus a wrap-around count. It sits between a hardware scheduler (command side) and the timer's s1 slave port (bus side).

---
 rtl/nios_ii_system_timer_master.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/nios_ii_system_timer_master.sv
// Hardware master for the 16-bit interval timer slave (s1 port).
// Programs the period, starts the timer, polls status, clears each timeout
// and reports it as a tick pulse plus a wrapping tick counter.
// Optional build macro TIMER_MASTER_SNAPSHOT_EN adds a snapshot read path
// (cmd_snap, snapshot_value, snapshot_valid).
//
// state          | meaning
// ---------------+-------------------------------------------------------
// ST_IDLE        | waiting for cmd_start (or a snapshot request)
// ST_WR_PL       | bus write period[15:0] to address 2
// ST_WR_PH       | bus write period[31:16] to address 3
// ST_WR_CTRL     | bus write START/CONT to control (address 1)
// ST_POLL_WAIT   | counting down idle cycles between status reads
// ST_RD_STAT     | bus read of status (address 0)
// ST_RD_STAT_WAIT| read data returned, test TO
// ST_WR_CLR      | bus write 0 to status, tick pulse
// ST_WR_STOP     | bus write STOP to control
// ST_SN_WR       | bus write 0 to snap_l to latch the live counter
// ST_SN_RD_L     | bus read of snap_l
// ST_SN_RD_L_WAIT| capture low half, issue snap_h read
// ST_SN_RD_H     | bus read of snap_h in flight
// ST_SN_RD_H_WAIT| capture high half, publish snapshot

module nios_ii_system_timer_master #(
  parameter int POLL_INTERVAL = 16,
  parameter int TICK_COUNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_start,
  input  logic                    cmd_stop,
  input  logic [31:0]             cmd_period,
  input  logic                    cmd_continuous,
`ifdef TIMER_MASTER_SNAPSHOT_EN
  input  logic                    cmd_snap,
  output logic [31:0]             snapshot_value,
  output logic                    snapshot_valid,
`endif
  output logic                    busy,
  output logic                    running,
  output logic                    tick,
  output logic [TICK_COUNT_W-1:0] tick_count,
  output logic [2:0]              m_address,
  output logic                    m_chipselect,
  output logic                    m_write_n,
  output logic [15:0]             m_writedata,
  input  logic [15:0]             m_readdata
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_POLL_WAIT,
    ST_RD_STAT,
    ST_RD_STAT_WAIT,
    ST_WR_CLR,
    ST_WR_STOP
`ifdef TIMER_MASTER_SNAPSHOT_EN
    , ST_SN_WR,
    ST_SN_RD_L,
    ST_SN_RD_L_WAIT,
    ST_SN_RD_H,
    ST_SN_RD_H_WAIT
`endif
  } state_t;

  localparam logic [2:0]  ADDR_STATUS   = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL  = 3'd1;
  localparam logic [2:0]  ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0]  ADDR_PERIOD_H = 3'd3;
`ifdef TIMER_MASTER_SNAPSHOT_EN
  localparam logic [2:0]  ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0]  ADDR_SNAP_H   = 3'd5;
`endif
  localparam logic [15:0] CTRL_STOP     = 16'h0008;
  localparam logic [15:0] POLL_RELOAD   = 16'(POLL_INTERVAL - 1);

  state_t      state;
  logic [15:0] poll_cnt;
  logic [15:0] period_hi_q;
  logic        cont_q;
  logic        stop_pending;
`ifdef TIMER_MASTER_SNAPSHOT_EN
  logic        snap_pending;
  logic        snap_from_poll;
  logic [15:0] snap_lo;
`endif

  // Only the TO bit of the status word drives control flow.
  logic rd_unused;
  assign rd_unused = ^m_readdata[15:1];

  assign busy = (state != ST_IDLE);

  // Sequencer: state, registered bus outputs, tick reporting and pending requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      poll_cnt       <= '0;
      period_hi_q    <= '0;
      cont_q         <= 1'b0;
      stop_pending   <= 1'b0;
      running        <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      m_address      <= '0;
      m_chipselect   <= 1'b0;
      m_write_n      <= 1'b1;
      m_writedata    <= '0;
`ifdef TIMER_MASTER_SNAPSHOT_EN
      snap_pending   <= 1'b0;
      snap_from_poll <= 1'b0;
      snap_lo        <= '0;
      snapshot_value <= '0;
      snapshot_valid <= 1'b0;
`endif
    end else begin
      // Bus and pulse outputs default to idle; states below override.
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      tick         <= 1'b0;
`ifdef TIMER_MASTER_SNAPSHOT_EN
      snapshot_valid <= 1'b0;
      if (cmd_snap) snap_pending <= 1'b1;
`endif
      // A stop outside IDLE/POLL_WAIT is remembered until polling resumes.
      if (cmd_stop && state != ST_IDLE && state != ST_POLL_WAIT)
        stop_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            period_hi_q  <= cmd_period[31:16];
            cont_q       <= cmd_continuous;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_address    <= ADDR_PERIOD_L;
            m_writedata  <= cmd_period[15:0];
            state        <= ST_WR_PL;
          end
`ifdef TIMER_MASTER_SNAPSHOT_EN
          else if (snap_pending || cmd_snap) begin
            snap_pending   <= 1'b0;
            snap_from_poll <= 1'b0;
            m_chipselect   <= 1'b1;
            m_write_n      <= 1'b0;
            m_address      <= ADDR_SNAP_L;
            m_writedata    <= 16'h0000;
            state          <= ST_SN_WR;
          end
`endif
        end
        ST_WR_PL: begin
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_PERIOD_H;
          m_writedata  <= period_hi_q;
          state        <= ST_WR_PH;
        end
        ST_WR_PH: begin
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_CONTROL;
          m_writedata  <= {12'h000, 1'b0, 1'b1, cont_q, 1'b0};
          running      <= 1'b1;
          state        <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          poll_cnt <= POLL_RELOAD;
          state    <= ST_POLL_WAIT;
        end
        ST_POLL_WAIT: begin
          if (stop_pending || cmd_stop) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_address    <= ADDR_CONTROL;
            m_writedata  <= CTRL_STOP;
            running      <= 1'b0;
            stop_pending <= 1'b0;
            state        <= ST_WR_STOP;
          end else if (poll_cnt == 16'd0) begin
            m_chipselect <= 1'b1;
            m_address    <= ADDR_STATUS;
            state        <= ST_RD_STAT;
          end
`ifdef TIMER_MASTER_SNAPSHOT_EN
          else if (snap_pending || cmd_snap) begin
            snap_pending   <= 1'b0;
            snap_from_poll <= 1'b1;
            m_chipselect   <= 1'b1;
            m_write_n      <= 1'b0;
            m_address      <= ADDR_SNAP_L;
            m_writedata    <= 16'h0000;
            state          <= ST_SN_WR;
          end
`endif
          else begin
            poll_cnt <= poll_cnt - 16'd1;
          end
        end
        ST_RD_STAT: begin
          state <= ST_RD_STAT_WAIT;
        end
        ST_RD_STAT_WAIT: begin
          if (m_readdata[0]) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_address    <= ADDR_STATUS;
            m_writedata  <= 16'h0000;
            tick         <= 1'b1;
            tick_count   <= tick_count + TICK_COUNT_W'(1);
            state        <= ST_WR_CLR;
          end else begin
            poll_cnt <= POLL_RELOAD;
            state    <= ST_POLL_WAIT;
          end
        end
        ST_WR_CLR: begin
          if (cont_q) begin
            poll_cnt <= POLL_RELOAD;
            state    <= ST_POLL_WAIT;
          end else begin
            running      <= 1'b0;
            stop_pending <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_WR_STOP: begin
          stop_pending <= 1'b0;
          state        <= ST_IDLE;
        end
`ifdef TIMER_MASTER_SNAPSHOT_EN
        ST_SN_WR: begin
          m_chipselect <= 1'b1;
          m_address    <= ADDR_SNAP_L;
          state        <= ST_SN_RD_L;
        end
        ST_SN_RD_L: begin
          state <= ST_SN_RD_L_WAIT;
        end
        ST_SN_RD_L_WAIT: begin
          snap_lo      <= m_readdata;
          m_chipselect <= 1'b1;
          m_address    <= ADDR_SNAP_H;
          state        <= ST_SN_RD_H;
        end
        ST_SN_RD_H: begin
          state <= ST_SN_RD_H_WAIT;
        end
        ST_SN_RD_H_WAIT: begin
          snapshot_value <= {m_readdata, snap_lo};
          snapshot_valid <= 1'b1;
          if (snap_from_poll) begin
            poll_cnt <= POLL_RELOAD;
            state    <= ST_POLL_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
